// File: rtl/sgpr_pkg.sv
// sgpr_pkg: shared widths, FSM states and lane masks for the SGPR load write sequencer
package sgpr_pkg;
  localparam int SGPR_ADDR_W = 9;
  localparam int SGPR_BEAT_DW = 4;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} sgpr_state_e;
  localparam logic [3:0] MASK_1DW = 4'b0001;
  localparam logic [3:0] MASK_2DW = 4'b0011;
  localparam logic [3:0] MASK_4DW = 4'b1111;
endpackage

// File: rtl/sgpr_ld_wr_seq_if.sv
// sgpr_ld_wr_seq_if: load-response, SGPR write-port and completion signals
interface sgpr_ld_wr_seq_if import sgpr_pkg::*; #(
  parameter int MAX_DWORDS = 16,
  parameter int TAG_W = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic [SGPR_ADDR_W-1:0]  req_addr;
  logic [4:0]              req_dwords;
  logic [32*MAX_DWORDS-1:0] req_data;
  logic [TAG_W-1:0]        req_tag;
  logic                    wr_stall;
  logic [SGPR_BEAT_DW-1:0] wr_en;
  logic [SGPR_ADDR_W-1:0]  wr_addr;
  logic [32*SGPR_BEAT_DW-1:0] wr_data;
  logic                    done_valid;
  logic [TAG_W-1:0]        done_tag;
  logic                    done_err;
  modport master (
    output req_valid, req_addr, req_dwords, req_data, req_tag, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data, done_valid, done_tag, done_err
  );
  modport slave (
    input  req_valid, req_addr, req_dwords, req_data, req_tag, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data, done_valid, done_tag, done_err
  );
endinterface

// File: rtl/sgpr_ld_size_decode.sv
// sgpr_ld_size_decode: maps load size and address alignment to legality, lane mask and beat count
module sgpr_ld_size_decode import sgpr_pkg::*; (
  input  logic [4:0] dwords,
  input  logic [1:0] addr_lo,
  output logic       legal,
  output logic [3:0] mask,
  output logic [2:0] beats
);
  // sizes of 4+ dwords are quad-aligned and use full beats; 8 and 16 map to dwords/4 beats
  always_comb begin
    legal = (dwords inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) &&
            ((dwords == 5'd2) ? !addr_lo[0] : (dwords >= 5'd4) ? (addr_lo == 2'b00) : 1'b1);
    mask  = (dwords == 5'd1) ? MASK_1DW : (dwords == 5'd2) ? MASK_2DW : MASK_4DW;
    beats = (dwords < 5'd4) ? 3'd1 : dwords[4:2];
  end
endmodule

// File: rtl/sgpr_ld_wr_seq.sv
// sgpr_ld_wr_seq: drains scalar-load return data into SGPR write port 0 in aligned beats
module sgpr_ld_wr_seq import sgpr_pkg::*; #(
  parameter int MAX_DWORDS = 16,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic rst_n,
  sgpr_ld_wr_seq_if.slave bus
);
  localparam int BUF_W = 32 * MAX_DWORDS;
  localparam int BEAT_W = 32 * SGPR_BEAT_DW;
  sgpr_state_e            state_q, state_d;
  logic [SGPR_ADDR_W-1:0] addr_q, addr_d;
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic [2:0]             beats_q, beats_d;
  logic [3:0]             mask_q, mask_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   err_q, err_d;
  logic                   legal;
  logic [3:0]             dec_mask;
  logic [2:0]             dec_beats;

  sgpr_ld_size_decode u_dec (
    .dwords (bus.req_dwords),
    .addr_lo(bus.req_addr[1:0]),
    .legal  (legal),
    .mask   (dec_mask),
    .beats  (dec_beats)
  );

  // state and capture registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      beats_q <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      beats_q <= beats_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  // capture in IDLE, advance one beat per unstalled WRITE cycle, pulse completion in DONE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    beats_d = beats_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        buf_d   = bus.req_data;
        tag_d   = bus.req_tag;
        mask_d  = dec_mask;
        beats_d = dec_beats;
        err_d   = !legal;
        state_d = legal ? WRITE : DONE;
      end
      WRITE: if (!bus.wr_stall) begin
        buf_d   = buf_q >> BEAT_W;
        addr_d  = addr_q + SGPR_ADDR_W'(SGPR_BEAT_DW);
        beats_d = beats_q - 3'd1;
        state_d = (beats_q == 3'd1) ? DONE : WRITE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.wr_en      = (state_q == WRITE && !bus.wr_stall) ? mask_q : 4'b0000;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = buf_q[BEAT_W-1:0];
  assign bus.done_valid = (state_q == DONE);
  assign bus.done_tag   = tag_q;
  assign bus.done_err   = err_q;
endmodule

// File: tb/tb_sgpr_ld_wr_seq.sv
// tb_sgpr_ld_wr_seq: directed checks of beats, stalls, illegal sizes, wrap and reset abort
module tb_sgpr_ld_wr_seq;
  logic clk;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  logic [511:0] d;

  sgpr_ld_wr_seq_if #(.MAX_DWORDS(16), .TAG_W(6)) bus ();

  sgpr_ld_wr_seq #(.MAX_DWORDS(16), .TAG_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic send(input logic [8:0] a, input logic [4:0] n, input logic [5:0] t, input logic [511:0] data);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_dwords = n;
    bus.req_tag    = t;
    bus.req_data   = data;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [3:0] en, input logic [8:0] a, input logic [127:0] data);
    @(negedge clk);
    chk({tag, "_en"}, 128'(bus.wr_en), 128'(en));
    chk({tag, "_addr"}, 128'(bus.wr_addr), 128'(a));
    chk({tag, "_data"}, bus.wr_data, data);
  endtask

  task automatic fin(input string tag, input logic [5:0] t, input logic err);
    @(negedge clk);
    chk({tag, "_done"}, 128'(bus.done_valid), 128'(1'b1));
    chk({tag, "_tag"}, 128'(bus.done_tag), 128'(t));
    chk({tag, "_err"}, 128'(bus.done_err), 128'(err));
    chk({tag, "_en_done"}, 128'(bus.wr_en), 128'(4'b0000));
    chk({tag, "_rdy_done"}, 128'(bus.req_ready), 128'(1'b0));
    @(negedge clk);
    chk({tag, "_idle_rdy"}, 128'(bus.req_ready), 128'(1'b1));
    chk({tag, "_idle_done"}, 128'(bus.done_valid), 128'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_dwords = '0;
    bus.req_tag = '0;
    bus.req_data = '0;
    bus.wr_stall = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("rst_en", 128'(bus.wr_en), 128'(4'b0000));
    chk("rst_addr", 128'(bus.wr_addr), 128'(9'h000));
    chk("rst_data", bus.wr_data, 128'h0);
    chk("rst_done", 128'(bus.done_valid), 128'(1'b0));
    chk("rst_tag", 128'(bus.done_tag), 128'(6'h00));
    chk("rst_err", 128'(bus.done_err), 128'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    d = mk(32'hA000_0000);
    send(9'h040, 5'd16, 6'd5, d);
    beat("w16_b0", 4'hF, 9'h040, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    chk("w16_rdy_write", 128'(bus.req_ready), 128'(1'b0));
    beat("w16_b1", 4'hF, 9'h044, {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004});
    beat("w16_b2", 4'hF, 9'h048, {32'hA000_000B, 32'hA000_000A, 32'hA000_0009, 32'hA000_0008});
    beat("w16_b3", 4'hF, 9'h04C, {32'hA000_000F, 32'hA000_000E, 32'hA000_000D, 32'hA000_000C});
    fin("w16", 6'd5, 1'b0);
    d = mk(32'hB000_0000);
    send(9'h013, 5'd1, 6'd1, d);
    beat("w1", 4'b0001, 9'h013, {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000});
    fin("w1", 6'd1, 1'b0);
    d = mk(32'hC000_0000);
    send(9'h022, 5'd2, 6'd2, d);
    beat("w2", 4'b0011, 9'h022, {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    fin("w2", 6'd2, 1'b0);
    d = mk(32'hD000_0000);
    send(9'h100, 5'd8, 6'd7, d);
    beat("st_b0", 4'hF, 9'h100, {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000});
    @(posedge clk);
    #1 bus.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_en_stalled", 128'(bus.wr_en), 128'(4'b0000));
      chk("st_addr_stalled", 128'(bus.wr_addr), 128'(9'h104));
      chk("st_done_stalled", 128'(bus.done_valid), 128'(1'b0));
    end
    @(posedge clk);
    #1 bus.wr_stall = 1'b0;
    beat("st_b1", 4'hF, 9'h104, {32'hD000_0007, 32'hD000_0006, 32'hD000_0005, 32'hD000_0004});
    fin("st", 6'd7, 1'b0);
    send(9'h002, 5'd4, 6'd9, d);
    fin("ill4", 6'd9, 1'b1);
    send(9'h000, 5'd3, 6'd10, d);
    fin("ill3", 6'd10, 1'b1);
    d = mk(32'hE000_0000);
    send(9'h1FC, 5'd8, 6'd3, d);
    beat("wrap_b0", 4'hF, 9'h1FC, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000});
    beat("wrap_b1", 4'hF, 9'h000, {32'hE000_0007, 32'hE000_0006, 32'hE000_0005, 32'hE000_0004});
    fin("wrap", 6'd3, 1'b0);
    d = mk(32'hF000_0000);
    send(9'h080, 5'd16, 6'd11, d);
    beat("ra_b0", 4'hF, 9'h080, {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000});
    beat("ra_b1", 4'hF, 9'h084, {32'hF000_0007, 32'hF000_0006, 32'hF000_0005, 32'hF000_0004});
    rst_n = 1'b0;
    #1;
    chk("ra_en_rst", 128'(bus.wr_en), 128'(4'b0000));
    chk("ra_rdy_rst", 128'(bus.req_ready), 128'(1'b1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ra_no_done", 128'(bus.done_valid), 128'(1'b0));
      chk("ra_no_wr", 128'(bus.wr_en), 128'(4'b0000));
    end
    d = mk(32'h1234_0000);
    send(9'h010, 5'd4, 6'd12, d);
    beat("post_b0", 4'hF, 9'h010, {32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000});
    fin("post", 6'd12, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
